alu_exec_mc: RTL and testbench
==============================

// Module: alu_exec_mc
// PURPOSE
//  Multicycle-datapath execute unit: ALU-control decode plus a registered ALU in one block.
//  Adds shifts, XOR, SLTU, and (optionally) iterative RV32M MUL/MULHU/DIVU/REMU.
//  Uses a start/done handshake so the main control FSM waits in its Execute state until done.
//  Sits between the SrcA/SrcB muxes and the ALUOut register.
// PARAMETERS
//  XLEN    32  operand/result width; must be even and >= 8
//  CTRL_W  4   width of internal ALUControl code
// PORTS
//  clk        in   1     clock, rising edge
//  reset_n    in   1     synchronous reset, active-low
//  start      in   1     operation request; sampled only when busy=0
//  ALUOp      in   2     00 add, 01 sub(branch), 10 funct-decoded, 11 reserved
//  op_5       in   1     opcode bit 5 (1 = R-type)
//  funct3     in   3     instruction funct3
//  funct7_5   in   1     instruction funct7[5]
//  funct7_0   in   1     instruction funct7[0] (M-extension select)
//  SrcA       in   XLEN  operand A
//  SrcB       in   XLEN  operand B
//  busy       out  1     operation in progress
//  done       out  1     one-cycle pulse: ALUResult/Zero/illegal valid
//  ALUResult  out  XLEN  result, held until the next done
//  Zero       out  1     (ALUResult == 0), updated with ALUResult
//  illegal    out  1     unsupported encoding, updated with done
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): state IDLE; busy, done, illegal, ALUResult = 0; Zero = 1.
//   Reset mid-operation aborts it. No done is produced.
//  Decode, ALUControl codes:
//   0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU,
//   0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL, 1011 MULHU, 1100 DIVU, 1101 REMU
//   ALUOp 00 -> ADD. ALUOp 01 -> SUB. ALUOp 11 -> illegal.
//   ALUOp 10 with funct3:
//    000 -> SUB if op_5&funct7_5, else ADD
//    001 SLL; 010 SLT; 011 SLTU; 100 XOR; 110 OR; 111 AND
//    101 -> SRA if funct7_5, else SRL
//   ALUOp 10 & op_5 & funct7_0 -> M op by funct3:
//    000 MUL, 011 MULHU, 101 DIVU, 111 REMU; any other funct3 -> illegal
//  Arithmetic rules:
//   Shift amount = SrcB[$clog2(XLEN)-1:0]. SLT signed compare, SLTU unsigned; result zero-extended.
//   MUL = low XLEN bits of the unsigned product. MULHU = high XLEN bits.
//   DIVU/REMU are unsigned, restoring algorithm.
//   Divide by zero: DIVU = all ones, REMU = SrcA.
//  FSM states IDLE, MULT, DIVI, FIN:
//   IDLE: start=1 latches SrcA/SrcB and the decoded code; busy=1 from the next cycle.
//    Simple op or illegal -> FIN, with the result computed into the result register.
//    MUL/MULHU -> MULT. DIVU/REMU with SrcB!=0 -> DIVI. Divide-by-zero -> FIN.
//   MULT, DIVI: exactly XLEN iterations (one bit per cycle, counter 0..XLEN-1), then FIN.
//   FIN: done=1 for one cycle, busy=0, ALUResult/Zero/illegal update; -> IDLE.
//    start is accepted again in the cycle after FIN.
//  Latency from the start edge to the done cycle:
//   simple, illegal, divide-by-zero: 2 cycles
//   MUL/DIV: XLEN+2 cycles
//  Handshake boundaries:
//   start while busy=1 is ignored and does not affect operands.
//   Inputs may change freely after the start edge.
//  Illegal op: ALUResult = 0, Zero = 1, illegal = 1.
// CONFIGURATION
//  ALU_MULDIV_EN defined:
//   M decode, MULT/DIVI states and iterative datapath are present.
//  ALU_MULDIV_EN undefined:
//   Any M encoding (ALUOp 10 & op_5 & funct7_0) -> illegal, 2-cycle latency.
//   No multiply/divide logic is instantiated.
// TESTING
//  1. Base decode: ALUOp=00, A=5, B=7 -> ALUResult=12, Zero=0, done 2 cycles after start.
//     ALUOp=01, A=B=9 -> ALUResult=0, Zero=1.
//  2. R-type decode: funct3=000, op_5=1, funct7_5=1, A=3, B=5 -> 0xFFFFFFFE.
//     Same with op_5=0 -> 8.
//     funct3=101, funct7_5=1, A=0x80000000, B=4 -> 0xF8000000. funct7_5=0 -> 0x08000000.
//     funct3=011, A=1, B=0xFFFFFFFF -> 1. funct3=010, same operands -> 0.
//  3. Multiply (ALU_MULDIV_EN):
//     MUL, A=0xFFFFFFFF, B=2 -> 0xFFFFFFFE. MULHU, same operands -> 1.
//     done exactly 34 cycles after start; busy high throughout.
//  4. Divide (ALU_MULDIV_EN):
//     DIVU 100/7 -> 14; REMU 100/7 -> 2.
//     DIVU x/0 -> 0xFFFFFFFF in 2 cycles; REMU 0x1234/0 -> 0x1234.
//  5. Handshake: start pulse at cycle 5 of a MUL with different operands -> ignored; result unchanged.
//     reset_n=0 at cycle 10 -> busy=0, no done, ALUResult=0.
//  6. Illegal: ALUOp=11 -> illegal=1, ALUResult=0.
//     Without ALU_MULDIV_EN: MUL encoding -> illegal=1 in 2 cycles.

Source files
------------

// File: rtl/alu_exec_mc.sv
// alu_exec_mc: multicycle-datapath execute unit.
// Decodes ALUOp/funct fields into an internal ALU control code, latches the
// operands on start, and reports the registered result with a one-cycle done.
// Simple ops finish in 2 cycles; MUL/MULHU/DIVU/REMU iterate one bit per cycle.
// Optional feature macro: ALU_MULDIV_EN (iterative RV32M multiply/divide).
module alu_exec_mc #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      ALUOp,
    input  logic            op_5,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            illegal
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [CTRL_W-1:0] C_ADD   = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] C_SUB   = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] C_AND   = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] C_OR    = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] C_XOR   = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] C_SLT   = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] C_SLTU  = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] C_SLL   = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] C_SRL   = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] C_SRA   = CTRL_W'(9);
`ifdef ALU_MULDIV_EN
    localparam logic [CTRL_W-1:0] C_MUL   = CTRL_W'(10);
    localparam logic [CTRL_W-1:0] C_MULHU = CTRL_W'(11);
    localparam logic [CTRL_W-1:0] C_DIVU  = CTRL_W'(12);
    localparam logic [CTRL_W-1:0] C_REMU  = CTRL_W'(13);
`endif

    typedef enum logic [1:0] {IDLE, MULT, DIVI, FIN} state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] dec_code;
    logic              dec_ill;
    logic [SH_W-1:0]   shamt;
    logic [XLEN-1:0]   simple_res;
    logic [XLEN-1:0]   res_q;
    logic              ill_q;
    logic [XLEN-1:0]   fin_res;

`ifdef ALU_MULDIV_EN
    // hi_q/lo_q hold {product high, product low} or {remainder, quotient}
    logic [CTRL_W-1:0] code_q;
    logic              iter_q;
    logic [XLEN-1:0]   hi_q, lo_q, opnd_q;
    logic [SH_W-1:0]   cnt_q;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              is_mul, is_div;
`endif

    assign shamt = SrcB[SH_W-1:0];
    assign busy  = (state_q != IDLE);

    // ALU control decode from ALUOp and instruction fields
    always_comb begin
        dec_code = C_ADD;
        dec_ill  = 1'b0;
        case (ALUOp)
            2'b00: dec_code = C_ADD;
            2'b01: dec_code = C_SUB;
            2'b10: begin
                if (op_5 && funct7_0) begin
`ifdef ALU_MULDIV_EN
                    case (funct3)
                        3'b000:  dec_code = C_MUL;
                        3'b011:  dec_code = C_MULHU;
                        3'b101:  dec_code = C_DIVU;
                        3'b111:  dec_code = C_REMU;
                        default: dec_ill  = 1'b1;
                    endcase
`else
                    dec_ill = 1'b1;
`endif
                end else begin
                    case (funct3)
                        3'b000:  dec_code = (op_5 && funct7_5) ? C_SUB : C_ADD;
                        3'b001:  dec_code = C_SLL;
                        3'b010:  dec_code = C_SLT;
                        3'b011:  dec_code = C_SLTU;
                        3'b100:  dec_code = C_XOR;
                        3'b101:  dec_code = funct7_5 ? C_SRA : C_SRL;
                        3'b110:  dec_code = C_OR;
                        default: dec_code = C_AND;
                    endcase
                end
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Single-cycle result for everything that does not iterate
    always_comb begin
        simple_res = '0;
        case (dec_code)
            C_ADD:  simple_res = SrcA + SrcB;
            C_SUB:  simple_res = SrcA - SrcB;
            C_AND:  simple_res = SrcA & SrcB;
            C_OR:   simple_res = SrcA | SrcB;
            C_XOR:  simple_res = SrcA ^ SrcB;
            C_SLT:  simple_res = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            C_SLTU: simple_res = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
            C_SLL:  simple_res = SrcA << shamt;
            C_SRL:  simple_res = SrcA >> shamt;
            C_SRA:  simple_res = $signed(SrcA) >>> shamt;
`ifdef ALU_MULDIV_EN
            // Only divide-by-zero takes these through the simple path
            C_DIVU: simple_res = '1;
            C_REMU: simple_res = SrcA;
`endif
            default: simple_res = '0;
        endcase
        if (dec_ill) simple_res = '0;
    end

`ifdef ALU_MULDIV_EN
    assign is_mul    = (dec_code == C_MUL) || (dec_code == C_MULHU);
    assign is_div    = (dec_code == C_DIVU) || (dec_code == C_REMU);
    // Shift-add multiply step and restoring-divide trial subtraction
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
`endif

    // Result presented at FIN: iterative ops pick their half of hi/lo
    always_comb begin
        fin_res = res_q;
`ifdef ALU_MULDIV_EN
        if (iter_q) begin
            case (code_q)
                C_MUL:   fin_res = lo_q;
                C_MULHU: fin_res = hi_q;
                C_DIVU:  fin_res = lo_q;
                default: fin_res = hi_q;
            endcase
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FIN;
`ifdef ALU_MULDIV_EN
                    if (is_mul)                     state_d = MULT;
                    else if (is_div && SrcB != '0)  state_d = DIVI;
`endif
                end
            end
`ifdef ALU_MULDIV_EN
            MULT: if (cnt_q == SH_W'(XLEN-1)) state_d = FIN;
            DIVI: if (cnt_q == SH_W'(XLEN-1)) state_d = FIN;
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done      <= 1'b0;
            illegal   <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            res_q     <= '0;
            ill_q     <= 1'b0;
`ifdef ALU_MULDIV_EN
            code_q    <= C_ADD;
            iter_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        res_q <= simple_res;
                        ill_q <= dec_ill;
`ifdef ALU_MULDIV_EN
                        code_q <= dec_code;
                        iter_q <= (state_d == MULT) || (state_d == DIVI);
                        cnt_q  <= '0;
                        hi_q   <= '0;
                        if (is_mul) begin
                            lo_q   <= SrcB;
                            opnd_q <= SrcA;
                        end else begin
                            lo_q   <= SrcA;
                            opnd_q <= SrcB;
                        end
`endif
                    end
                end
`ifdef ALU_MULDIV_EN
                MULT: begin
                    {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
                    cnt_q        <= cnt_q + SH_W'(1);
                end
                DIVI: begin
                    if (!div_diff[XLEN]) begin
                        hi_q <= div_diff[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_q <= div_shift[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + SH_W'(1);
                end
`endif
                FIN: begin
                    done      <= 1'b1;
                    ALUResult <= fin_res;
                    Zero      <= (fin_res == '0);
                    illegal   <= ill_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_mc.sv
// tb_alu_exec_mc: directed + scoreboard bench for alu_exec_mc.
// Multiply/divide checks are compiled in when ALU_MULDIV_EN is defined.
module tb_alu_exec_mc;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      ALUOp = 2'b00;
    logic            op_5 = 1'b0;
    logic [2:0]      funct3 = 3'b000;
    logic            funct7_5 = 1'b0;
    logic            funct7_0 = 1'b0;
    logic [XLEN-1:0] SrcA = '0;
    logic [XLEN-1:0] SrcB = '0;
    logic            busy, done, Zero, illegal;
    logic [XLEN-1:0] ALUResult;

    always #5 clk = ~clk;

    alu_exec_mc #(.XLEN(XLEN), .CTRL_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ALUOp(ALUOp), .op_5(op_5),
        .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
        .ALUResult(ALUResult), .Zero(Zero), .illegal(illegal)
    );

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request (start high from this negedge) and queue its expectation
    task automatic launch(input string tag, input logic [1:0] op, input logic o5,
                          input logic [2:0] f3, input logic f75, input logic f70,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic ill, input int lat);
        exp_t e;
        e.res = res; e.ill = ill; e.lat = lat; e.tag = tag;
        sb.push_back(e);
        ALUOp = op; op_5 = o5; funct3 = f3; funct7_5 = f75; funct7_0 = f70;
        SrcA = a; SrcB = b; start = 1'b1;
    endtask

    // Wait (bounded) for done, scramble inputs after the start edge, optionally
    // pulse a second start at cycle inject_at, then compare against the queue head
    task automatic wait_done(input int inject_at);
        exp_t e;
        int   cyc;
        logic d;
        logic busy_ok;
        cyc = 0; d = 1'b0; busy_ok = 1'b1;
        while (!d && cyc < 100) begin
            @(negedge clk);
            cyc++;
            d = done;
            if (!d && busy !== 1'b1) busy_ok = 1'b0;
            if (cyc == 1) begin
                start = 1'b0;
                SrcA = $urandom; SrcB = $urandom;
                ALUOp = 2'($urandom); funct3 = 3'($urandom);
                op_5 = 1'($urandom); funct7_5 = 1'($urandom); funct7_0 = 1'($urandom);
            end
            if (inject_at != 0 && cyc == inject_at) start = 1'b1;
            if (inject_at != 0 && cyc == inject_at + 1) start = 1'b0;
        end
        e = sb.pop_front();
        check({e.tag, " done"}, 32'(d), 32'd1);
        check({e.tag, " latency"}, 32'(cyc), 32'(e.lat));
        check({e.tag, " busy while running"}, 32'(busy_ok), 32'd1);
        check({e.tag, " busy at done"}, 32'(busy), 32'd0);
        check({e.tag, " result"}, ALUResult, e.res);
        check({e.tag, " zero"}, 32'(Zero), 32'(e.res == 32'd0));
        check({e.tag, " illegal"}, 32'(illegal), 32'(e.ill));
        @(negedge clk);
        check({e.tag, " done pulse"}, 32'(done), 32'd0);
    endtask

    // Assert reset at cycle 'at' of the running op; it must vanish without done
    task automatic abort_at(input int at);
        exp_t e;
        logic seen;
        seen = 1'b0;
        for (int cyc = 1; cyc <= at; cyc++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            if (cyc == 1) start = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, " abort busy"}, 32'(busy), 32'd0);
        check({e.tag, " abort result"}, ALUResult, 32'd0);
        check({e.tag, " abort zero"}, 32'(Zero), 32'd1);
        reset_n = 1'b1;
        repeat (XLEN + 4) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({e.tag, " no done"}, 32'(seen), 32'd0);
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic f75,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb_s;
        logic [31:0] r;
        sa = a; sb_s = b;
        case (f3)
            3'd0: if (f75) r = a - b; else r = a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = (sa < sb_s) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: if (f75) r = sa >>> b[4:0]; else r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] a, b, r;
        logic [2:0]  f3;
        logic        f75;
        logic [63:0] p;

        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", ALUResult, 32'd0);
        check("reset zero", 32'(Zero), 32'd1);
        check("reset illegal", 32'(illegal), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        launch("add", 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 2);
        wait_done(0);
        launch("sub beq", 2'b01, 1'b0, 3'd0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 1'b0, 2);
        wait_done(0);
        launch("r sub", 2'b10, 1'b1, 3'd0, 1'b1, 1'b0, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 2);
        wait_done(0);
        launch("i add", 2'b10, 1'b0, 3'd0, 1'b1, 1'b0, 32'd3, 32'd5, 32'd8, 1'b0, 2);
        wait_done(0);
        launch("i add f7_0", 2'b10, 1'b0, 3'd0, 1'b0, 1'b1, 32'd3, 32'd5, 32'd8, 1'b0, 2);
        wait_done(0);
        launch("sra", 2'b10, 1'b1, 3'd5, 1'b1, 1'b0, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 2);
        wait_done(0);
        launch("srl", 2'b10, 1'b1, 3'd5, 1'b0, 1'b0, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 2);
        wait_done(0);
        launch("sltu", 2'b10, 1'b1, 3'd3, 1'b0, 1'b0, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 2);
        wait_done(0);
        launch("slt", 2'b10, 1'b1, 3'd2, 1'b0, 1'b0, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 2);
        wait_done(0);
        launch("sll mask", 2'b10, 1'b1, 3'd1, 1'b0, 1'b0, 32'd1, 32'h25, 32'h20, 1'b0, 2);
        wait_done(0);
        launch("xor", 2'b10, 1'b1, 3'd4, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 2);
        wait_done(0);
        launch("or", 2'b10, 1'b1, 3'd6, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 2);
        wait_done(0);
        launch("and", 2'b10, 1'b1, 3'd7, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 2);
        wait_done(0);

        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom; f3 = 3'($urandom); f75 = 1'($urandom);
            if (f3 != 3'd0 && f3 != 3'd5) f75 = 1'b0;
            r = model(f3, f75, a, b);
            launch("rand simple", 2'b10, 1'b1, f3, f75, 1'b0, a, b, r, 1'b0, 2);
            wait_done(0);
        end

        launch("add pre-illegal", 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 2);
        wait_done(0);
        launch("aluop 11", 2'b11, 1'b1, 3'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 1'b1, 2);
        wait_done(0);
        launch("m funct3 001", 2'b10, 1'b1, 3'd1, 1'b0, 1'b1, 32'd5, 32'd7, 32'd0, 1'b1, 2);
        wait_done(0);
        launch("start held", 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 2);
        wait_done(1);

`ifdef ALU_MULDIV_EN
        launch("mul", 2'b10, 1'b1, 3'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, XLEN + 2);
        wait_done(0);
        launch("mulhu", 2'b10, 1'b1, 3'd3, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, XLEN + 2);
        wait_done(0);
        launch("divu", 2'b10, 1'b1, 3'd5, 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, XLEN + 2);
        wait_done(0);
        launch("remu", 2'b10, 1'b1, 3'd7, 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 1'b0, XLEN + 2);
        wait_done(0);
        launch("divu by 0", 2'b10, 1'b1, 3'd5, 1'b0, 1'b1, 32'd77, 32'd0, 32'hFFFFFFFF, 1'b0, 2);
        wait_done(0);
        launch("remu by 0", 2'b10, 1'b1, 3'd7, 1'b0, 1'b1, 32'h1234, 32'd0, 32'h1234, 1'b0, 2);
        wait_done(0);
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom; p = 64'(a) * 64'(b);
            launch("rand mul", 2'b10, 1'b1, 3'd0, 1'b0, 1'b1, a, b, p[31:0], 1'b0, XLEN + 2);
            wait_done(0);
            launch("rand mulhu", 2'b10, 1'b1, 3'd3, 1'b0, 1'b1, a, b, p[63:32], 1'b0, XLEN + 2);
            wait_done(0);
            b = b >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd3;
            launch("rand divu", 2'b10, 1'b1, 3'd5, 1'b0, 1'b1, a, b, a / b, 1'b0, XLEN + 2);
            wait_done(0);
            launch("rand remu", 2'b10, 1'b1, 3'd7, 1'b0, 1'b1, a, b, a % b, 1'b0, XLEN + 2);
            wait_done(0);
        end
        launch("mul start ignored", 2'b10, 1'b1, 3'd0, 1'b0, 1'b1, 32'd3, 32'd5, 32'd15, 1'b0, XLEN + 2);
        wait_done(5);
        launch("mul reset", 2'b10, 1'b1, 3'd0, 1'b0, 1'b1, 32'd3, 32'd5, 32'd15, 1'b0, XLEN + 2);
        abort_at(10);
`else
        launch("mul no m", 2'b10, 1'b1, 3'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b1, 2);
        wait_done(0);
        launch("divu no m", 2'b10, 1'b1, 3'd5, 1'b0, 1'b1, 32'd100, 32'd7, 32'd0, 1'b1, 2);
        wait_done(0);
        launch("add pre-reset", 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 1'b0, 2);
        wait_done(0);
        launch("add reset", 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 32'd4, 32'd4, 32'd8, 1'b0, 2);
        abort_at(1);
`endif
        launch("after reset", 2'b10, 1'b1, 3'd0, 1'b1, 1'b0, 32'd10, 32'd3, 32'd7, 1'b0, 2);
        wait_done(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
